// File: rtl/segs_pkg.sv
// Shared constants, register map and converter state type for the
// seven-segment BCD display source.
package segs_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned BIN_W      = 20;

    // Bus register map
    localparam logic [1:0] ADDR_HEX  = 2'd0;
    localparam logic [1:0] ADDR_BIN  = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;

    // CTRL register bit positions
    localparam int unsigned CTRL_BUSY_BIT  = 31;
    localparam int unsigned CTRL_OVF_BIT   = 30;
    localparam int unsigned CTRL_BLANK_BIT = 8;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } conv_state_e;

    // Double-dabble correction applied to one BCD digit before each shift.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per cycle.
// start_i loads the operand (restarting any conversion in flight), abort_i
// drops back to idle. done_o is high for the single cycle bcd_o is final.
module bin2bcd_seq
    import segs_pkg::*;
#(
    parameter int unsigned BIN_W      = segs_pkg::BIN_W,
    parameter int unsigned BCD_DIGITS = segs_pkg::NUM_DIGITS + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [BIN_W-1:0]        operand_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*BCD_DIGITS-1:0] bcd_o
);

    localparam int unsigned BcdW   = 4 * BCD_DIGITS;
    localparam int unsigned ShiftW = BcdW + BIN_W;
    localparam int unsigned CntW   = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    conv_state_e       state_q;
    logic [CntW-1:0]   cnt_q;
    logic [ShiftW-1:0] shift_q;
    logic [ShiftW-1:0] shift_d;

    // One double-dabble step: correct every BCD digit, then shift left by one.
    always_comb begin
        shift_d = shift_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            shift_d[BIN_W + 4*i +: 4] = dabble_adjust(shift_q[BIN_W + 4*i +: 4]);
        end
        shift_d = shift_d << 1;
    end

    // Converter FSM: load on start, BIN_W shift cycles, one done cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (abort_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else if (start_i) begin
            state_q <= StConv;
            cnt_q   <= '0;
            shift_q <= {{BcdW{1'b0}}, operand_i};
        end else begin
            unique case (state_q)
                StConv: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(BIN_W - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);
    assign bcd_o  = shift_q[ShiftW-1 -: BcdW];

endmodule

// File: rtl/segs_bcd_source.sv
// Bus-mapped source for the six-digit seven-segment multiplexer. Accepts a
// raw hex value or a binary value converted to BCD, and drives per-digit
// enables from a mask.
// Build option: SEGS_BLANK_ZEROS_EN adds leading-zero blanking in decimal mode.
module segs_bcd_source
    import segs_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = segs_pkg::NUM_DIGITS,
    parameter int unsigned BIN_W      = segs_pkg::BIN_W
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    WriteEnable,
    input  logic [1:0]              Address,
    input  logic [31:0]             WriteData,
    output logic [31:0]             ReadData,
    output logic                    Busy,
    output logic [4*NUM_DIGITS-1:0] Data,
    output logic [NUM_DIGITS-1:0]   DisplayEnables
);

    localparam int unsigned DataW     = 4 * NUM_DIGITS;
    localparam int unsigned BcdDigits = NUM_DIGITS + 1;

    logic [DataW-1:0]       data_q;
    logic [NUM_DIGITS-1:0]  en_q;
    logic [NUM_DIGITS-1:0]  en_d;
    logic [NUM_DIGITS-1:0]  mask_q;
    logic [BIN_W-1:0]       bin_q;
    logic                   ovf_q;
    logic                   blank_q;
    logic                   wr_hex;
    logic                   wr_bin;
    logic                   wr_ctrl;
    logic                   conv_busy;
    logic                   conv_done;
    logic [4*BcdDigits-1:0] conv_bcd;
    logic [31:0]            ctrl_word;
    logic                   wdata_unused;

    assign wr_hex  = WriteEnable && (Address == ADDR_HEX);
    assign wr_bin  = WriteEnable && (Address == ADDR_BIN);
    assign wr_ctrl = WriteEnable && (Address == ADDR_CTRL);

    // High write-data bits beyond the hex field carry nothing.
    assign wdata_unused = ^WriteData[31:DataW];

    bin2bcd_seq #(
        .BIN_W      (BIN_W),
        .BCD_DIGITS (BcdDigits)
    ) u_bin2bcd (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .start_i   (wr_bin),
        .abort_i   (wr_hex),
        .operand_i (WriteData[BIN_W-1:0]),
        .busy_o    (conv_busy),
        .done_o    (conv_done),
        .bcd_o     (conv_bcd)
    );

    // Display data, overflow, operand and mask registers; any write landing on
    // the done edge supersedes the conversion result.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_q <= '0;
            ovf_q  <= 1'b0;
            bin_q  <= '0;
            mask_q <= '1;
            en_q   <= '1;
        end else begin
            if (wr_hex) begin
                data_q <= WriteData[DataW-1:0];
                ovf_q  <= 1'b0;
            end else if (conv_done && !wr_bin) begin
                data_q <= conv_bcd[DataW-1:0];
                ovf_q  <= (conv_bcd[4*BcdDigits-1 -: 4] != 4'd0);
            end
            if (wr_bin) begin
                bin_q <= WriteData[BIN_W-1:0];
            end
            if (wr_ctrl) begin
                mask_q <= WriteData[NUM_DIGITS-1:0];
            end
            en_q <= en_d;
        end
    end

`ifdef SEGS_BLANK_ZEROS_EN
    logic dec_mode_q;
    logic seen_nz;

    // Blank flag and display mode (decimal after a BIN write, hex after HEX).
    always_ff @(posedge Clock) begin
        if (Reset) begin
            blank_q    <= 1'b0;
            dec_mode_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                blank_q <= WriteData[CTRL_BLANK_BIT];
            end
            if (wr_hex) begin
                dec_mode_q <= 1'b0;
            end else if (wr_bin) begin
                dec_mode_q <= 1'b1;
            end
        end
    end

    // Mask off digits above the most significant nonzero digit; digit 0 stays.
    always_comb begin
        en_d    = mask_q;
        seen_nz = 1'b0;
        if (dec_mode_q && blank_q) begin
            for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
                seen_nz = seen_nz | (data_q[4*i +: 4] != 4'd0);
                if (!seen_nz) begin
                    en_d[i] = 1'b0;
                end
            end
        end
    end
`else
    assign blank_q = 1'b0;

    // Without blanking the enables simply follow the mask.
    always_comb begin
        en_d = mask_q;
    end
`endif

    // CTRL readback word assembly.
    always_comb begin
        ctrl_word                   = '0;
        ctrl_word[CTRL_BUSY_BIT]    = conv_busy;
        ctrl_word[CTRL_OVF_BIT]     = ovf_q;
        ctrl_word[CTRL_BLANK_BIT]   = blank_q;
        ctrl_word[NUM_DIGITS-1:0]   = mask_q;
    end

    // Combinational register readback selected by Address.
    always_comb begin
        ReadData = '0;
        case (Address)
            ADDR_HEX:  ReadData = 32'(data_q);
            ADDR_BIN:  ReadData = 32'(bin_q);
            ADDR_CTRL: ReadData = ctrl_word;
            default:   ReadData = '0;
        endcase
    end

    assign Busy           = conv_busy;
    assign Data           = data_q;
    assign DisplayEnables = en_q;

endmodule

// File: tb/tb_segs_bcd_source.sv
// Bench for segs_bcd_source: a cycle-level reference model built from
// decimal arithmetic and a completion countdown, compared every cycle,
// plus directed literal checks.
module tb_segs_bcd_source;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        WriteEnable = 1'b0;
    logic [1:0]  Address = 2'd2;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Busy;
    logic [23:0] Data;
    logic [5:0]  DisplayEnables;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    segs_bcd_source dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .WriteEnable    (WriteEnable),
        .Address        (Address),
        .WriteData      (WriteData),
        .ReadData       (ReadData),
        .Busy           (Busy),
        .Data           (Data),
        .DisplayEnables (DisplayEnables)
    );

    always #5 Clock = ~Clock;

    // Reference model state
    logic [23:0] m_data  = '0;
    logic [5:0]  m_mask  = 6'h3F;
    logic [5:0]  m_en    = 6'h3F;
    logic [19:0] m_bin   = '0;
    bit          m_ovf   = 1'b0;
    bit          m_dec   = 1'b0;
    bit          m_blank = 1'b0;
    int          m_rem   = 0;
    int unsigned m_val   = 0;

    function automatic logic [23:0] to_bcd(input int unsigned v);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] model_en(input logic [5:0] mask, input logic [23:0] d,
                                            input bit dec, input bit blank);
        logic [5:0] e;
        bit nz;
        e = mask;
        if (dec && blank) begin
            for (int i = 1; i < 6; i++) begin
                nz = 1'b0;
                for (int j = i; j < 6; j++) begin
                    if (d[4*j +: 4] != 4'd0) nz = 1'b1;
                end
                if (!nz) e[i] = 1'b0;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {8'b0, m_data};
            2'd1:    return {12'b0, m_bin};
            2'd2:    return {(m_rem != 0), m_ovf, 21'b0, m_blank, 2'b0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    // Model update: conversion finishes 21 edges after the accepting edge.
    always @(posedge Clock) begin : model
        logic [5:0] next_en;
        bit completing;
        bit wh;
        bit wb;
        bit wc;
        next_en    = model_en(m_mask, m_data, m_dec, m_blank);
        completing = (m_rem == 1);
        wh = WriteEnable && (Address == 2'd0);
        wb = WriteEnable && (Address == 2'd1);
        wc = WriteEnable && (Address == 2'd2);
        if (Reset) begin
            m_data = '0; m_mask = 6'h3F; m_en = 6'h3F; m_bin = '0;
            m_ovf = 1'b0; m_dec = 1'b0; m_blank = 1'b0; m_rem = 0; m_val = 0;
        end else begin
            m_en = next_en;
            if (m_rem > 0) m_rem--;
            if (wh) begin
                m_data = WriteData[23:0];
                m_ovf  = 1'b0;
                m_dec  = 1'b0;
                m_rem  = 0;
            end else if (wb) begin
                m_bin = WriteData[19:0];
                m_val = WriteData[19:0];
                m_dec = 1'b1;
                m_rem = 21;
            end else if (completing) begin
                m_data = to_bcd(m_val % 1000000);
                m_ovf  = (m_val > 999999);
            end
            if (wc) begin
                m_mask = WriteData[5:0];
`ifdef SEGS_BLANK_ZEROS_EN
                m_blank = WriteData[8];
`endif
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge Clock) begin
        if (checking) begin
            cmp("model Data", {8'b0, Data}, {8'b0, m_data});
            cmp("model DisplayEnables", {26'b0, DisplayEnables}, {26'b0, m_en});
            cmp("model Busy", {31'b0, Busy}, {31'b0, (m_rem != 0)});
            cmp("model ReadData", ReadData, model_rd(Address));
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge Clock);
        #1;
        WriteEnable = 1'b1;
        Address     = a;
        WriteData   = d;
        @(posedge Clock);
        #1;
        WriteEnable = 1'b0;
        Address     = 2'd2;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (Busy === 1'b1 && cycles < 40) begin
            @(posedge Clock);
            #1;
            cycles++;
        end
    endtask

    int cyc;

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        Reset    = 1'b0;
        checking = 1'b1;

        cmp("reset Data", {8'b0, Data}, 32'h0);
        cmp("reset DisplayEnables", {26'b0, DisplayEnables}, 32'h3F);
        cmp("reset Busy", {31'b0, Busy}, 32'h0);
        cmp("reset CTRL", ReadData, 32'h0000003F);

        bus_write(2'd0, 32'h00ABCDEF);
        cmp("hex Data", {8'b0, Data}, 32'h00ABCDEF);
        cmp("hex Busy", {31'b0, Busy}, 32'h0);

        bus_write(2'd1, 32'd123456);
        cmp("bin busy after write", {31'b0, Busy}, 32'h1);
        wait_idle(cyc);
        cmp("bin 123456 latency", cyc, 21);
        cmp("bin 123456 Data", {8'b0, Data}, 32'h00123456);
        cmp("bin 123456 overflow", {31'b0, ReadData[30]}, 32'h0);

        bus_write(2'd1, 32'd1048575);
        wait_idle(cyc);
        cmp("bin max latency", cyc, 21);
        cmp("bin max Data", {8'b0, Data}, 32'h00048575);
        cmp("bin max overflow", {31'b0, ReadData[30]}, 32'h1);
        Address = 2'd1;
        #1;
        cmp("bin readback", ReadData, 32'h000FFFFF);
        Address = 2'd2;

        bus_write(2'd1, 32'd999999);
        repeat (8) @(posedge Clock);
        bus_write(2'd1, 32'd42);
        wait_idle(cyc);
        cmp("restart latency", cyc, 21);
        cmp("restart Data", {8'b0, Data}, 32'h00000042);
        cmp("restart overflow cleared", {31'b0, ReadData[30]}, 32'h0);

`ifdef SEGS_BLANK_ZEROS_EN
        bus_write(2'd2, 32'h0000013F);
        cmp("ctrl readback blank", ReadData, 32'h0000013F);
        bus_write(2'd1, 32'd42);
        wait_idle(cyc);
        @(posedge Clock);
        #1;
        cmp("blank 42 enables", {26'b0, DisplayEnables}, 32'h03);
        bus_write(2'd1, 32'd0);
        wait_idle(cyc);
        @(posedge Clock);
        #1;
        cmp("blank 0 enables", {26'b0, DisplayEnables}, 32'h01);
        bus_write(2'd2, 32'h0000003F);
`else
        bus_write(2'd2, 32'h0000013F);
        cmp("ctrl readback no blank", ReadData, 32'h0000003F);
        bus_write(2'd1, 32'd0);
        wait_idle(cyc);
        @(posedge Clock);
        #1;
        cmp("zero Data", {8'b0, Data}, 32'h0);
        cmp("no blank enables", {26'b0, DisplayEnables}, 32'h3F);
`endif

        // HEX write aborts a running conversion
        bus_write(2'd1, 32'd5);
        repeat (3) @(posedge Clock);
        bus_write(2'd0, 32'h00111111);
        cmp("abort Busy", {31'b0, Busy}, 32'h0);
        repeat (25) @(posedge Clock);
        #1;
        cmp("abort Data", {8'b0, Data}, 32'h00111111);

        bus_write(2'd2, 32'h00000005);
        @(posedge Clock);
        #1;
        cmp("mask enables", {26'b0, DisplayEnables}, 32'h05);
        bus_write(2'd2, 32'h0000003F);

        // HEX write on the done edge wins
        bus_write(2'd1, 32'd7);
        repeat (19) @(posedge Clock);
        bus_write(2'd0, 32'h00222222);
        cmp("done-edge hex Data", {8'b0, Data}, 32'h00222222);
        cmp("done-edge hex Busy", {31'b0, Busy}, 32'h0);

        // BIN write on the done edge restarts
        bus_write(2'd1, 32'd8);
        repeat (19) @(posedge Clock);
        bus_write(2'd1, 32'd9);
        cmp("done-edge bin Data held", {8'b0, Data}, 32'h00222222);
        wait_idle(cyc);
        cmp("done-edge bin latency", cyc, 21);
        cmp("done-edge bin Data", {8'b0, Data}, 32'h00000009);

        // Reset mid-conversion
        bus_write(2'd1, 32'd99);
        repeat (5) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        cmp("midreset Data", {8'b0, Data}, 32'h0);
        cmp("midreset Busy", {31'b0, Busy}, 32'h0);
        repeat (25) @(posedge Clock);
        #1;
        cmp("midreset Data later", {8'b0, Data}, 32'h0);

        repeat (2) @(posedge Clock);
        #1;
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
